// File: rtl/mips_instr_decoder_if.sv
// Decoder bus: stage IR in, instruction-class flags and sticky RI status out.
interface mips_instr_decoder_if;
    logic [31:0] IR;
    logic        MemWrite;
    logic        MemRead;
    logic        sw;
    logic        sh;
    logic        sb;
    logic        lw;
    logic        lh;
    logic        lhu;
    logic        lb;
    logic        lbu;
    logic        RegWrite;
    logic        branch;
    logic        jump;
    logic        md;
    logic        cp0;
    logic        ri;
    logic        ri_seen;

    // Pipeline stage side: supplies IR, consumes the flags.
    modport master (
        output IR,
        input  MemWrite, MemRead, sw, sh, sb, lw, lh, lhu, lb, lbu,
        input  RegWrite, branch, jump, md, cp0, ri, ri_seen
    );

    // Decoder side.
    modport slave (
        input  IR,
        output MemWrite, MemRead, sw, sh, sb, lw, lh, lhu, lb, lbu,
        output RegWrite, branch, jump, md, cp0, ri, ri_seen
    );
endinterface

// File: rtl/mips_instr_decoder.sv
// Per-stage MIPS instruction-class decoder with a sticky reserved-instruction flag.
module mips_instr_decoder (
    input  logic                  clk,
    input  logic                  reset,
    mips_instr_decoder_if.slave   bus
);
    localparam logic [31:0] EretWord = 32'h4200_0018;

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] funct;

    logic known;
    logic reg_write;
    logic is_branch;
    logic is_jump;
    logic is_md;
    logic is_cp0;
    logic ri;
    logic ri_seen_q;

    assign op    = bus.IR[31:26];
    assign rs    = bus.IR[25:21];
    assign rt    = bus.IR[20:16];
    assign funct = bus.IR[5:0];

    // Classify the non-memory instruction groups; anything left unmatched is reserved.
    always_comb begin
        known     = 1'b0;
        reg_write = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        is_md     = 1'b0;
        is_cp0    = 1'b0;
        unique case (op)
            6'h00: begin
                unique case (funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B: begin
                        known     = 1'b1;
                        reg_write = 1'b1;
                    end
                    6'h08: begin
                        known   = 1'b1;
                        is_jump = 1'b1;
                    end
                    6'h09: begin
                        known     = 1'b1;
                        is_jump   = 1'b1;
                        reg_write = 1'b1;
                    end
                    6'h10, 6'h12: begin
                        known     = 1'b1;
                        is_md     = 1'b1;
                        reg_write = 1'b1;
                    end
                    6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: begin
                        known = 1'b1;
                        is_md = 1'b1;
                    end
                    default: ;
                endcase
            end
            6'h01: begin
                if (rt == 5'h00 || rt == 5'h01) begin
                    known     = 1'b1;
                    is_branch = 1'b1;
                end
            end
            6'h02: begin
                known   = 1'b1;
                is_jump = 1'b1;
            end
            6'h03: begin
                known     = 1'b1;
                is_jump   = 1'b1;
                reg_write = 1'b1;
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                known     = 1'b1;
                is_branch = 1'b1;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                known     = 1'b1;
                reg_write = 1'b1;
            end
            // Loads write a GPR; stores do not.
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                known     = 1'b1;
                reg_write = 1'b1;
            end
            6'h28, 6'h29, 6'h2B: begin
                known = 1'b1;
            end
            6'h10: begin
                if (bus.IR == EretWord) begin
                    known  = 1'b1;
                    is_cp0 = 1'b1;
                end else if (rs == 5'h00) begin
                    known     = 1'b1;
                    is_cp0    = 1'b1;
                    reg_write = 1'b1;
                end else if (rs == 5'h04) begin
                    known  = 1'b1;
                    is_cp0 = 1'b1;
                end
            end
            default: ;
        endcase
        ri = ~known;
    end

    // Drive the bus flags; memory flags are exact opcode matches.
    always_comb begin
        bus.sw       = (op == 6'h2B);
        bus.sh       = (op == 6'h29);
        bus.sb       = (op == 6'h28);
        bus.lw       = (op == 6'h23);
        bus.lh       = (op == 6'h21);
        bus.lhu      = (op == 6'h25);
        bus.lb       = (op == 6'h20);
        bus.lbu      = (op == 6'h24);
        bus.MemWrite = bus.sw | bus.sh | bus.sb;
        bus.MemRead  = bus.lw | bus.lh | bus.lhu | bus.lb | bus.lbu;
        bus.RegWrite = reg_write;
        bus.branch   = is_branch;
        bus.jump     = is_jump;
        bus.md       = is_md;
        bus.cp0      = is_cp0;
        bus.ri       = ri;
        bus.ri_seen  = ri_seen_q;
    end

    // Sticky RI status: set by any reserved instruction, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ri_seen_q <= 1'b0;
        end else begin
            ri_seen_q <= ri_seen_q | ri;
        end
    end
endmodule

// File: tb/tb_mips_instr_decoder.sv
// Directed bench for mips_instr_decoder: hand-computed flag vectors plus RI sticky behaviour.
module tb_mips_instr_decoder;
    // Flag vector bit positions.
    localparam logic [15:0] F_MW  = 16'h8000;
    localparam logic [15:0] F_MR  = 16'h4000;
    localparam logic [15:0] F_SW  = 16'h2000;
    localparam logic [15:0] F_SH  = 16'h1000;
    localparam logic [15:0] F_SB  = 16'h0800;
    localparam logic [15:0] F_LW  = 16'h0400;
    localparam logic [15:0] F_LH  = 16'h0200;
    localparam logic [15:0] F_LHU = 16'h0100;
    localparam logic [15:0] F_LB  = 16'h0080;
    localparam logic [15:0] F_LBU = 16'h0040;
    localparam logic [15:0] F_RW  = 16'h0020;
    localparam logic [15:0] F_BR  = 16'h0010;
    localparam logic [15:0] F_J   = 16'h0008;
    localparam logic [15:0] F_MD  = 16'h0004;
    localparam logic [15:0] F_CP0 = 16'h0002;
    localparam logic [15:0] F_RI  = 16'h0001;

    typedef struct packed {
        logic [31:0] ir;
        logic [15:0] exp;
    } vec_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mips_instr_decoder_if bus ();

    mips_instr_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] flags();
        return {bus.MemWrite, bus.MemRead, bus.sw, bus.sh, bus.sb, bus.lw, bus.lh, bus.lhu,
                bus.lb, bus.lbu, bus.RegWrite, bus.branch, bus.jump, bus.md, bus.cp0, bus.ri};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [31:0] ir, input logic [15:0] exp);
        @(negedge clk);
        bus.IR = ir;
        #1;
        check($sformatf("flags IR=%08h", ir), {16'h0, flags()}, {16'h0, exp});
    endtask

    vec_t good[24];

    initial begin
        errors = 0;
        checks = 0;
        good[0]  = '{32'hAD09_0004, F_MW | F_SW};
        good[1]  = '{32'hA509_0002, F_MW | F_SH};
        good[2]  = '{32'hA109_0003, F_MW | F_SB};
        good[3]  = '{32'h8D09_0000, F_MR | F_LW  | F_RW};
        good[4]  = '{32'h8509_0000, F_MR | F_LH  | F_RW};
        good[5]  = '{32'h9509_0000, F_MR | F_LHU | F_RW};
        good[6]  = '{32'h8109_0000, F_MR | F_LB  | F_RW};
        good[7]  = '{32'h9109_0000, F_MR | F_LBU | F_RW};
        good[8]  = '{32'h0000_0000, F_RW};
        good[9]  = '{32'h4008_6000, F_CP0 | F_RW};
        good[10] = '{32'h4088_6000, F_CP0};
        good[11] = '{32'h4200_0018, F_CP0};
        good[12] = '{32'h03E0_0008, F_J};
        good[13] = '{32'h0060_F809, F_J | F_RW};
        good[14] = '{32'h0800_0000, F_J};
        good[15] = '{32'h0C00_0000, F_J | F_RW};
        good[16] = '{32'h1000_0000, F_BR};
        good[17] = '{32'h1C00_0000, F_BR};
        good[18] = '{32'h0401_0000, F_BR};
        good[19] = '{32'h0000_0018, F_MD};
        good[20] = '{32'h0000_0010, F_MD | F_RW};
        good[21] = '{32'h0000_0013, F_MD};
        good[22] = '{32'h3C01_1234, F_RW};
        good[23] = '{32'h0109_5020, F_RW};

        reset  = 1'b1;
        bus.IR = 32'h0;
        @(posedge clk);
        #1;
        check("ri_seen after reset", {31'h0, bus.ri_seen}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (good[i]) apply(good[i].ir, good[i].exp);
        @(posedge clk);
        #1;
        check("ri_seen clear on recognised stream", {31'h0, bus.ri_seen}, 32'h0);

        // Reserved encodings.
        apply(32'h0402_0000, F_RI);
        apply(32'h4040_0000, F_RI);
        apply(32'h0000_0001, F_RI);
        apply(32'hFC00_0000, F_RI);
        @(posedge clk);
        #1;
        check("ri_seen set", {31'h0, bus.ri_seen}, 32'h1);
        apply(32'h0000_003F, F_RI);
        apply(32'h0000_0000, F_RW);
        @(posedge clk);
        #1;
        check("ri_seen sticky", {31'h0, bus.ri_seen}, 32'h1);
        @(posedge clk);
        #1;
        check("ri_seen sticky 2", {31'h0, bus.ri_seen}, 32'h1);

        // One-cycle reset: clears ri_seen, combinational flags unaffected.
        @(negedge clk);
        reset  = 1'b1;
        bus.IR = 32'hAD09_0004;
        #1;
        check("flags during reset", {16'h0, flags()}, {16'h0, F_MW | F_SW});
        check("ri_seen before reset edge", {31'h0, bus.ri_seen}, 32'h1);
        @(posedge clk);
        #1;
        check("ri_seen cleared by reset", {31'h0, bus.ri_seen}, 32'h0);
        check("flags after reset edge", {16'h0, flags()}, {16'h0, F_MW | F_SW});
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ri_seen stays clear", {31'h0, bus.ri_seen}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
